// File: rtl/gcd_engine_if.sv
// Start/done handshake bundle between an operand-supplying front end and the GCD engine.
// The front end holds the master modport; the engine holds the slave modport.
interface gcd_engine_if #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 16
);
   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             err;
   logic             zero_in;
   logic [CNT_W-1:0] iter_count;

   modport master (
      output start, a_in, b_in,
      input  ready, busy, done, result, err, zero_in, iter_count
   );

   modport slave (
      input  start, a_in, b_in,
      output ready, busy, done, result, err, zero_in, iter_count
   );
endinterface

// File: rtl/gcd_engine.sv
// Iterative GCD engine (subtractive or binary/Stein) with a merged controller and datapath.
// Operands are captured on an accepted start; results are held from done until the next start.
module gcd_engine #(
   parameter int WIDTH    = 16,
   parameter int ALGO     = 0,
   parameter int CNT_W    = 16,
   parameter int MAX_ITER = 65535
) (
   input  logic        clk,
   input  logic        rst,
   gcd_engine_if.slave bus
);

   localparam int K_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] MAX_ITER_C = CNT_W'(MAX_ITER);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [K_W-1:0]   k_q, k_d;
   logic [CNT_W-1:0] iter_q, iter_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             err_q, err_d;
   logic             zero_q, zero_d;

   logic [WIDTH-1:0] step_a;
   logic [WIDTH-1:0] step_b;
   logic [K_W-1:0]   step_k;
   logic [WIDTH-1:0] equal_result;
   logic             a_gt_b;

   assign a_gt_b = (a_q > b_q);

   // One reduction step, applied only when none of the termination checks fire.
   always_comb begin
      step_a = a_q;
      step_b = b_q;
      step_k = k_q;
      if (ALGO == 1) begin
         if (!a_q[0] && !b_q[0]) begin
            step_a = a_q >> 1;
            step_b = b_q >> 1;
            step_k = k_q + 1'b1;
         end else if (!a_q[0]) begin
            step_a = a_q >> 1;
         end else if (!b_q[0]) begin
            step_b = b_q >> 1;
         end else if (a_gt_b) begin
            step_a = a_q - b_q;
         end else begin
            step_b = b_q - a_q;
         end
      end else begin
         if (a_gt_b) begin
            step_a = a_q - b_q;
         end else begin
            step_b = b_q - a_q;
         end
      end
   end

   // Stein removes common factors of two into k; they are restored on completion.
   assign equal_result = (ALGO == 1) ? (a_q << k_q) : a_q;

   always_comb begin
      // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      k_d      = k_q;
      iter_d   = iter_q;
      result_d = result_q;
      err_d    = err_q;
      zero_d   = zero_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               a_d     = bus.a_in;
               b_d     = bus.b_in;
               k_d     = '0;
               iter_d  = '0;
               err_d   = 1'b0;
               zero_d  = (bus.a_in == '0) || (bus.b_in == '0);
               state_d = S_RUN;
            end
         end

         S_RUN: begin
            if ((a_q == '0) || (b_q == '0)) begin
               result_d = a_q | b_q;
               state_d  = S_DONE;
            end else if (a_q == b_q) begin
               result_d = equal_result;
               state_d  = S_DONE;
            end else if (iter_q == MAX_ITER_C) begin
               err_d    = 1'b1;
               result_d = '0;
               state_d  = S_DONE;
            end else begin
               a_d    = step_a;
               b_d    = step_b;
               k_d    = step_k;
               iter_d = iter_q + 1'b1;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         k_q      <= '0;
         iter_q   <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         k_q      <= k_d;
         iter_q   <= iter_d;
         result_q <= result_d;
         err_q    <= err_d;
         zero_q   <= zero_d;
      end
   end

   assign bus.ready      = (state_q == S_IDLE);
   assign bus.busy       = (state_q == S_RUN);
   assign bus.done       = (state_q == S_DONE);
   assign bus.result     = result_q;
   assign bus.err        = err_q;
   assign bus.zero_in    = zero_q;
   assign bus.iter_count = iter_q;

endmodule

// File: tb/tb_gcd_engine.sv
// Bench for gcd_engine: three instances (subtractive, Stein, subtractive with MAX_ITER=10)
// share clk/rst; a vector table feeds a scoreboard that is checked on every done pulse.
module tb_gcd_engine;

   localparam int WIDTH = 16;
   localparam int CNT_W = 16;
   localparam int N_DUT = 3;

   typedef struct {
      int               dut;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] res;
      logic             err;
      logic             zin;
      int               iter;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [N_DUT-1:0] start_v, ready_v, busy_v, done_v, err_v, zero_v;
   logic [WIDTH-1:0] a_v      [N_DUT];
   logic [WIDTH-1:0] b_v      [N_DUT];
   logic [WIDTH-1:0] result_v [N_DUT];
   logic [CNT_W-1:0] iter_v   [N_DUT];

   gcd_engine_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus [N_DUT] ();

   for (genvar g = 0; g < N_DUT; g++) begin : g_dut
      gcd_engine #(
         .WIDTH   (WIDTH),
         .ALGO    ((g == 1) ? 1 : 0),
         .CNT_W   (CNT_W),
         .MAX_ITER((g == 2) ? 10 : 65535)
      ) u_dut (
         .clk(clk),
         .rst(rst),
         .bus(bus[g])
      );
      assign bus[g].start = start_v[g];
      assign bus[g].a_in  = a_v[g];
      assign bus[g].b_in  = b_v[g];
      assign ready_v[g]   = bus[g].ready;
      assign busy_v[g]    = bus[g].busy;
      assign done_v[g]    = bus[g].done;
      assign err_v[g]     = bus[g].err;
      assign zero_v[g]    = bus[g].zero_in;
      assign result_v[g]  = bus[g].result;
      assign iter_v[g]    = bus[g].iter_count;
   end

   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc      = 0;
   int   acc_cyc [N_DUT];
   vec_t exp_q [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic vec_t mk(input int dut, input int a, input int b, input int res,
                               input bit err, input bit zin, input int iter);
      vec_t v;
      v.dut  = dut;
      v.a    = WIDTH'(a);
      v.b    = WIDTH'(b);
      v.res  = WIDTH'(res);
      v.err  = err;
      v.zin  = zin;
      v.iter = iter;
      return v;
   endfunction

   // Accept edge bookkeeping: inputs and DUT state read here are the pre-edge values.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < N_DUT; i++)
         if (!rst && start_v[i] && ready_v[i]) acc_cyc[i] <= cyc;
   end

   // Scoreboard: every done pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      vec_t e;
      if (!rst) begin
         for (int i = 0; i < N_DUT; i++) begin
            if (done_v[i]) begin
               if (exp_q.size() == 0) begin
                  check($sformatf("unexpected_done_dut%0d", i), 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check($sformatf("done_dut_%0d_%0d", e.a, e.b), 64'(i), 64'(e.dut));
                  check($sformatf("result_%0d_%0d", e.a, e.b), 64'(result_v[i]), 64'(e.res));
                  check($sformatf("err_%0d_%0d", e.a, e.b), 64'(err_v[i]), 64'(e.err));
                  check($sformatf("zero_in_%0d_%0d", e.a, e.b), 64'(zero_v[i]), 64'(e.zin));
                  check($sformatf("iter_%0d_%0d", e.a, e.b), 64'(iter_v[i]), 64'(e.iter));
                  check($sformatf("latency_%0d_%0d", e.a, e.b), 64'(cyc - acc_cyc[i]),
                        64'(e.iter + 2));
               end
            end
         end
      end
   end

   task automatic issue(input vec_t v);
      int t = 0;
      @(negedge clk);
      while (!ready_v[v.dut] && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("ready_before_start", 64'(ready_v[v.dut]), 1);
      a_v[v.dut]     = v.a;
      b_v[v.dut]     = v.b;
      start_v[v.dut] = 1'b1;
      exp_q.push_back(v);
      @(negedge clk);
      start_v[v.dut] = 1'b0;
   endtask

   task automatic wait_done(input int dut, input int budget);
      int t = 0;
      while (!done_v[dut] && t < budget) begin
         @(negedge clk);
         t++;
      end
      check($sformatf("done_seen_dut%0d", dut), 64'(done_v[dut]), 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl [$];
      int   t;

      // Subtractive
      tbl.push_back(mk(0, 12, 8, 4, 0, 0, 2));
      tbl.push_back(mk(0, 48, 180, 12, 0, 0, 6));
      tbl.push_back(mk(0, 17, 5, 1, 0, 0, 6));
      tbl.push_back(mk(0, 0, 7, 7, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 9, 9, 9, 0, 0, 0));
      // Stein
      tbl.push_back(mk(1, 12, 8, 4, 0, 0, 5));
      tbl.push_back(mk(1, 48, 180, 12, 0, 0, 10));
      tbl.push_back(mk(1, 17, 5, 1, 0, 0, 7));
      tbl.push_back(mk(1, 32768, 16384, 16384, 0, 0, 15));
      tbl.push_back(mk(1, 7, 0, 7, 0, 1, 0));
      tbl.push_back(mk(1, 9, 9, 9, 0, 0, 0));
      // Step limit of 10
      tbl.push_back(mk(2, 1000, 1, 0, 1, 0, 10));
      tbl.push_back(mk(2, 6, 4, 2, 0, 0, 2));
      tbl.push_back(mk(2, 11, 1, 1, 0, 0, 10));
      tbl.push_back(mk(2, 12, 1, 0, 1, 0, 10));
      tbl.push_back(mk(2, 6, 4, 2, 0, 0, 2));

      rst     = 1'b1;
      start_v = '0;
      for (int i = 0; i < N_DUT; i++) begin
         a_v[i] = '0;
         b_v[i] = '0;
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      for (int i = 0; i < N_DUT; i++) begin
         check($sformatf("rst_ready_dut%0d", i), 64'(ready_v[i]), 1);
         check($sformatf("rst_busy_dut%0d", i), 64'(busy_v[i]), 0);
         check($sformatf("rst_done_dut%0d", i), 64'(done_v[i]), 0);
         check($sformatf("rst_result_dut%0d", i), 64'(result_v[i]), 0);
         check($sformatf("rst_iter_dut%0d", i), 64'(iter_v[i]), 0);
         check($sformatf("rst_err_dut%0d", i), 64'(err_v[i]), 0);
      end

      // Reset in the middle of a long operation discards it.
      issue(mk(0, 1000, 3, 1, 0, 0, 0));
      repeat (4) @(negedge clk);
      check("mid_run_busy", 64'(busy_v[0]), 1);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_ready", 64'(ready_v[0]), 1);
      check("mid_rst_busy", 64'(busy_v[0]), 0);
      check("mid_rst_iter", 64'(iter_v[0]), 0);
      check("mid_rst_result", 64'(result_v[0]), 0);
      repeat (20) @(negedge clk);

      foreach (tbl[i]) begin
         issue(tbl[i]);
         wait_done(tbl[i].dut, 100);
      end

      // Start pulses with fresh operands during RUN and DONE must be ignored.
      issue(mk(0, 48, 180, 12, 0, 0, 6));
      t = 0;
      while (!done_v[0] && t < 50) begin
         start_v[0] = 1'b1;
         a_v[0]     = WIDTH'($urandom);
         b_v[0]     = WIDTH'($urandom);
         @(negedge clk);
         t++;
      end
      check("pulse_done_seen", 64'(done_v[0]), 1);
      start_v[0] = 1'b1;
      a_v[0]     = 16'd100;
      b_v[0]     = 16'd75;
      @(negedge clk);
      start_v[0] = 1'b0;
      check("pulse_idle_ready", 64'(ready_v[0]), 1);
      check("pulse_idle_busy", 64'(busy_v[0]), 0);
      check("pulse_held_result", 64'(result_v[0]), 12);
      check("pulse_held_iter", 64'(iter_v[0]), 6);
      repeat (5) @(negedge clk);
      check("pulse_still_result", 64'(result_v[0]), 12);

      // Start held high: three chained operations, one IDLE cycle between each.
      repeat (3) exp_q.push_back(mk(1, 12, 8, 4, 0, 0, 5));
      @(negedge clk);
      a_v[1]     = 16'd12;
      b_v[1]     = 16'd8;
      start_v[1] = 1'b1;
      for (int n = 0; n < 3; n++) begin
         wait_done(1, 100);
         if (n == 2) start_v[1] = 1'b0;
         @(negedge clk);
         check($sformatf("chain_idle_ready_%0d", n), 64'(ready_v[1]), 1);
         check($sformatf("chain_idle_busy_%0d", n), 64'(busy_v[1]), 0);
         if (n < 2) begin
            @(negedge clk);
            check($sformatf("chain_rerun_busy_%0d", n), 64'(busy_v[1]), 1);
         end
      end
      repeat (10) @(negedge clk);
      check("chain_stopped_ready", 64'(ready_v[1]), 1);
      check("pending_expectations", 64'(exp_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/gcd_engine.md
Name: gcd_engine

Overview:
- Parametrised GCD unit. Controller FSM and operand datapath are merged into one block, with a start/done handshake.
- Successor to the fixed subtractive GCD controller. Adds:
  - WIDTH generalisation
  - selectable algorithm: repeated subtraction or binary (Stein)
  - zero-operand handling
  - step counter
  - iteration timeout
- Sits between a register/bus front end that supplies operands and consumers that sample the result on done.

Parameters:
- WIDTH, 16, operand and result width in bits (≥2).
- ALGO, 0, 0 = subtractive (one subtract per step); 1 = binary/Stein (one shift or subtract per step).
- CNT_W, 16, width of the step counter.
- MAX_ITER, 65535, step limit; reaching it aborts with err (must be < 2^CNT_W).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request; sampled only when ready=1.
- a_in  in  WIDTH  operand A; captured on an accepted start.
- b_in  in  WIDTH  operand B; captured on an accepted start.
- ready  out  1  high in IDLE only.
- busy  out  1  high in RUN only.
- done  out  1  one-cycle pulse when result/err/iter_count are valid.
- result  out  WIDTH  GCD; held from done until the next accepted start.
- err  out  1  timeout flag; valid with done, held like result.
- zero_in  out  1  set if either captured operand was 0; held like result.
- iter_count  out  CNT_W  steps executed for the last operation; held like result.

Behaviour:
- Reset (any state, including mid-RUN):
  - state = IDLE
  - ready = 1; busy = done = err = zero_in = 0
  - result = 0; iter_count = 0
  - internal A, B, k = 0
  - Any operation in flight is discarded; no done is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge → A ← a_in, B ← b_in, k ← 0, iter_count ← 0, err ← 0, zero_in ← (a_in==0 | b_in==0); go to RUN.
  - start=0 → stay.
- RUN, evaluated each cycle in priority order:
  1. A==0 or B==0 → result ← A|B (GCD(0,0)=0); go to DONE.
  2. A==B → result ← A (ALGO=0) or A<<k (ALGO=1, truncated to WIDTH, never overflows); go to DONE.
  3. iter_count==MAX_ITER → err ← 1, result ← 0; go to DONE.
  4. Otherwise perform one step and iter_count ← iter_count+1.
     - ALGO=0:
       - A>B → A ← A−B
       - else B ← B−A
     - ALGO=1:
       - both even → A ← A>>1, B ← B>>1, k ← k+1
       - only A even → A ← A>>1
       - only B even → B ← B>>1
       - both odd, A>B → A ← A−B
       - both odd, else → B ← B−A
- DONE:
  - done=1 for exactly this cycle.
  - Unconditionally return to IDLE; start during DONE is ignored.
- Arithmetic:
  - Unsigned subtraction only, always larger minus smaller, so no underflow.
  - k is clog2(WIDTH)+1 bits.
- Handshake and outputs:
  - start while busy or in DONE has no effect; operands are never re-sampled.
  - busy = (state==RUN), ready = (state==IDLE); outputs are registered or decoded from state, never from inputs combinationally.
- Latency (start edge to done high) = iter_count + 2 cycles. Zero or equal operands give iter_count=0 and latency 2.
- Back-to-back: the earliest next start is accepted on the edge where the state is IDLE again (the cycle after done).

Test Plan:
- Reset, then idle 5 cycles → ready=1, busy=0, done=0, result=0, iter_count=0; assert rst during RUN of GCD(1000,3) → next cycle IDLE, no done pulse.
- ALGO=0, WIDTH=16, start with a=12, b=8 → busy for 3 cycles, done pulse 2 cycles after the start edge plus 2 steps; result=4, iter_count=2, err=0.
- ALGO=1, a=12, b=8 → result=4, iter_count=5, k path exercised; a=48, b=180 → result=12.
- Zero operands: (0,7) → result=7, zero_in=1, iter_count=0, latency 2; (0,0) → result=0, zero_in=1; (9,9) → result=9, zero_in=0.
- Timeout: ALGO=0, MAX_ITER=10, a=1000, b=1 → done with err=1, result=0, iter_count=10; the next op (6,4) → err=0, result=2.
- Handshake: pulse start with new operands every cycle during RUN and DONE → ignored, result unchanged; start held high continuously → operations chain with exactly one IDLE cycle between done and the next RUN.
